// File: rtl/fcpu_pkg.sv
// Shared widths, opcodes and types for the fcpu core.
// Also holds the memory responder state type and opcode class helpers.
package fcpu_pkg;

    localparam int INSTR_W  = 5;
    localparam int RSV_ID_W = 4;
    localparam int DATA_W   = 32;
    localparam int CDB_W    = RSV_ID_W + DATA_W;

    localparam logic [INSTR_W-1:0] I_NOP    = 5'd0;
    localparam logic [INSTR_W-1:0] I_ADD    = 5'd1;
    localparam logic [INSTR_W-1:0] I_SUB    = 5'd2;
    localparam logic [INSTR_W-1:0] I_LOAD   = 5'd8;
    localparam logic [INSTR_W-1:0] I_LOADB  = 5'd9;
    localparam logic [INSTR_W-1:0] I_LOADR  = 5'd10;
    localparam logic [INSTR_W-1:0] I_STORE  = 5'd11;
    localparam logic [INSTR_W-1:0] I_STOREB = 5'd12;
    localparam logic [INSTR_W-1:0] I_STORER = 5'd13;
    localparam logic [INSTR_W-1:0] I_INPUT  = 5'd14;
    localparam logic [INSTR_W-1:0] I_OUTPUT = 5'd15;
    localparam logic [INSTR_W-1:0] I_JMP    = 5'd16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_RD,
        RESP,
        IN_WAIT,
        OUT_WAIT
    } mem_resp_state_t;

    function automatic logic is_load_op(input logic [INSTR_W-1:0] op);
        return op inside {I_LOAD, I_LOADB, I_LOADR};
    endfunction

    function automatic logic is_store_op(input logic [INSTR_W-1:0] op);
        return op inside {I_STORE, I_STOREB, I_STORER};
    endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is taken
// only when a pop frees a slot in the same cycle.
module fifo #(
    parameter int FIFO_DEPTH_W = 4,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam logic [FIFO_DEPTH_W:0] FULL_CNT = {1'b1, {FIFO_DEPTH_W{1'b0}}};

    logic [DATA_W-1:0]       mem [0:(1 << FIFO_DEPTH_W)-1];
    logic [FIFO_DEPTH_W-1:0] wr_ptr;
    logic [FIFO_DEPTH_W-1:0] rd_ptr;
    logic [FIFO_DEPTH_W:0]   count;
    logic                    do_push;
    logic                    do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/memory_responder.sv
// Memory functional unit target: data RAM loads/stores, RX/TX byte I/O,
// results returned in order on the CDB as {rsv_id, data}.
module memory_responder
    import fcpu_pkg::*;
#(
    parameter int RAM_ADDR_W      = 12,
    parameter int RX_FIFO_DEPTH_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    input  logic [INSTR_W-1:0]  i_opcode,
    input  logic [RSV_ID_W-1:0] i_rsv_id,
    input  logic [DATA_W-1:0]   i_address,
    input  logic [DATA_W-1:0]   i_data,
    output logic                i_ready,
    output logic [CDB_W-1:0]    o_cdb,
    output logic                o_cdb_valid,
    input  logic                o_cdb_ready,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    output logic                rx_ready,
    output logic                tx_valid,
    output logic [7:0]          tx_data,
    input  logic                tx_ready,
    output mem_resp_state_t     state_dbg
);

    // Every port pair is valid/ready: a transfer happens on the rising edge
    // where both are high; the sender holds payload stable until then.

    mem_resp_state_t       state;
    logic [RSV_ID_W-1:0]   rsv_q;
    logic [DATA_W-1:0]     ram [0:(1 << RAM_ADDR_W)-1];
    logic [DATA_W-1:0]     ram_q;
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic                  accept;
    logic                  rx_push;
    logic                  rx_pop;
    logic                  rx_full;
    logic                  rx_empty;
    logic [7:0]            rx_byte;
    logic                  unused_addr_bits;

    assign ram_idx          = i_address[RAM_ADDR_W-1:0];
    assign unused_addr_bits = ^i_address[DATA_W-1:RAM_ADDR_W];
    assign i_ready          = (state == IDLE) && !rst;
    assign accept           = i_valid && i_ready;
    assign rx_ready         = !rx_full && !rst;
    assign rx_push          = rx_valid && rx_ready;
    assign rx_pop           = (state == IN_WAIT) && !rx_empty;
    assign state_dbg        = state;

    fifo #(
        .FIFO_DEPTH_W(RX_FIFO_DEPTH_W),
        .DATA_W      (8)
    ) u_rx_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (rx_push),
        .din  (rx_data),
        .pop  (rx_pop),
        .dout (rx_byte),
        .full (rx_full),
        .empty(rx_empty)
    );

    // RAM survives reset; upper address bits alias onto the same words.
    always_ff @(posedge clk) begin
        if (accept && is_store_op(i_opcode)) begin
            ram[ram_idx] <= i_data;
        end
        if (accept && is_load_op(i_opcode)) begin
            ram_q <= ram[ram_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rsv_q       <= '0;
            o_cdb       <= '0;
            o_cdb_valid <= 1'b0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_load_op(i_opcode)) begin
                            rsv_q <= i_rsv_id;
                            state <= LOAD_RD;
                        end else if (i_opcode == I_INPUT) begin
                            rsv_q <= i_rsv_id;
                            state <= IN_WAIT;
                        end else if (i_opcode == I_OUTPUT) begin
                            tx_data  <= i_data[7:0];
                            tx_valid <= 1'b1;
                            state    <= OUT_WAIT;
                        end
                    end
                end
                LOAD_RD: begin
                    o_cdb       <= {rsv_q, ram_q};
                    o_cdb_valid <= 1'b1;
                    state       <= RESP;
                end
                IN_WAIT: begin
                    if (!rx_empty) begin
                        o_cdb       <= {rsv_q, {(DATA_W-8){1'b0}}, rx_byte};
                        o_cdb_valid <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (o_cdb_ready) begin
                        o_cdb_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                OUT_WAIT: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: directed scenarios with literal results plus
// a randomized phase, all checked every cycle against a transaction model.
module tb_memory_responder;
  import fcpu_pkg::*;

  localparam int RX_DEPTH = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                i_valid = 1'b0;
  logic [INSTR_W-1:0]  i_opcode = '0;
  logic [RSV_ID_W-1:0] i_rsv_id = '0;
  logic [DATA_W-1:0]   i_address = '0;
  logic [DATA_W-1:0]   i_data = '0;
  logic                i_ready;
  logic [CDB_W-1:0]    o_cdb;
  logic                o_cdb_valid;
  logic                o_cdb_ready = 1'b0;
  logic                rx_valid = 1'b0;
  logic [7:0]          rx_data = '0;
  logic                rx_ready;
  logic                tx_valid;
  logic [7:0]          tx_data;
  logic                tx_ready = 1'b0;
  mem_resp_state_t     state_dbg;

  // clock / reset
  always #5 clk = ~clk;

  memory_responder #(.RAM_ADDR_W(12), .RX_FIFO_DEPTH_W(4)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_opcode(i_opcode),
    .i_rsv_id(i_rsv_id), .i_address(i_address), .i_data(i_data),
    .i_ready(i_ready), .o_cdb(o_cdb), .o_cdb_valid(o_cdb_valid),
    .o_cdb_ready(o_cdb_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .state_dbg(state_dbg)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkv(input string name, input logic [CDB_W-1:0] act, input logic [CDB_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // transaction model / scoreboard
  logic [DATA_W-1:0]   ram_m [0:4095];
  logic [7:0]          rx_q[$];
  logic [CDB_W-1:0]    exp_q[$];
  bit                  chk_on = 0;
  bit                  rst_prev = 0;
  bit                  owe_cdb = 0;
  bit                  owe_tx = 0;
  int                  res_at = 0;
  int                  in_from = 0;
  int                  tx_from = 0;
  logic [RSV_ID_W-1:0] in_rsv = '0;
  logic [7:0]          tx_byte = '0;
  int                  cdb_hs = 0;
  int                  tx_hs = 0;

  function automatic bit m_is_load(input logic [INSTR_W-1:0] op);
    return (op == I_LOAD) || (op == I_LOADB) || (op == I_LOADR);
  endfunction

  function automatic bit m_is_store(input logic [INSTR_W-1:0] op);
    return (op == I_STORE) || (op == I_STOREB) || (op == I_STORER);
  endfunction

  always @(negedge clk) begin
    bit e_iready, e_cv, e_tv, e_rxr;
    logic [7:0] b;
    if (chk_on) begin
      e_iready = !rst && !owe_cdb && !owe_tx;
      e_cv     = owe_cdb && (res_at >= 0) && (cyc >= res_at);
      e_tv     = owe_tx && (cyc >= tx_from);
      e_rxr    = !rst && (rx_q.size() < RX_DEPTH);
      chk1("i_ready", i_ready, e_iready);
      chk1("cdb_valid", o_cdb_valid, e_cv);
      chk1("tx_valid", tx_valid, e_tv);
      chk1("rx_ready", rx_ready, e_rxr);
      chk1("state_idle", state_dbg == IDLE, !owe_cdb && !owe_tx);
      if (e_cv) chkv("cdb_data", o_cdb, exp_q[0]);
      if (e_tv) chkv("tx_data", CDB_W'(tx_data), CDB_W'(tx_byte));
      if (rst_prev) begin
        chkv("cdb_after_rst", o_cdb, '0);
        chkv("tx_after_rst", CDB_W'(tx_data), '0);
      end
      if (rst) begin
        owe_cdb = 0;
        owe_tx = 0;
        rx_q.delete();
        exp_q.delete();
      end else begin
        if (e_cv && o_cdb_ready) begin
          owe_cdb = 0;
          void'(exp_q.pop_front());
          cdb_hs++;
        end
        if (e_tv && tx_ready) begin
          owe_tx = 0;
          tx_hs++;
        end
        if (owe_cdb && res_at < 0 && cyc >= in_from && rx_q.size() > 0) begin
          b = rx_q.pop_front();
          exp_q.push_back({in_rsv, 24'h0, b});
          res_at = cyc + 1;
        end
        if (rx_valid && e_rxr) rx_q.push_back(rx_data);
        if (i_valid && e_iready) begin
          if (m_is_store(i_opcode)) begin
            ram_m[i_address[11:0]] = i_data;
          end else if (m_is_load(i_opcode)) begin
            owe_cdb = 1;
            res_at = cyc + 2;
            exp_q.push_back({i_rsv_id, ram_m[i_address[11:0]]});
          end else if (i_opcode == I_INPUT) begin
            owe_cdb = 1;
            res_at = -1;
            in_from = cyc + 1;
            in_rsv = i_rsv_id;
          end else if (i_opcode == I_OUTPUT) begin
            owe_tx = 1;
            tx_from = cyc + 1;
            tx_byte = i_data[7:0];
          end
        end
      end
      rst_prev = rst;
    end
    cyc++;
  end

  // driver tasks: all are entered and left 1 time unit after a rising edge
  task automatic issue(input logic [INSTR_W-1:0] op, input logic [RSV_ID_W-1:0] rsv,
                       input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] data);
    int n = 0;
    i_valid = 1'b1;
    i_opcode = op;
    i_rsv_id = rsv;
    i_address = addr;
    i_data = data;
    forever begin
      @(negedge clk);
      if (i_ready) break;
      n++;
      if (n > 500) begin
        timeout("issue");
        break;
      end
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data = b;
    forever begin
      @(negedge clk);
      if (rx_ready) break;
      n++;
      if (n > 500) begin
        timeout("send_byte");
        break;
      end
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_cdb(output logic [CDB_W-1:0] v);
    int n = 0;
    forever begin
      @(negedge clk);
      if (o_cdb_valid) break;
      n++;
      if (n > 500) begin
        timeout("wait_cdb");
        break;
      end
    end
    v = o_cdb;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit rand_ready = 0;
  bit rand_rx = 0;

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      o_cdb_ready = ($urandom_range(0, 3) != 0);
      tx_ready = ($urandom_range(0, 2) != 0);
    end
  end

  logic [INSTR_W-1:0] op_tab [12];
  logic [11:0]        idx_tab [8];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CDB_W-1:0] v;
    logic [DATA_W-1:0] a;
    int hs0;
    int n;

    op_tab = '{I_LOAD, I_LOADB, I_LOADR, I_STORE, I_STOREB, I_STORER,
               I_INPUT, I_INPUT, I_OUTPUT, I_NOP, I_ADD, I_JMP};
    idx_tab = '{12'h010, 12'h011, 12'h020, 12'hFFF, 12'h000, 12'h7A0, 12'h123, 12'h456};

    @(posedge clk);
    chk_on = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("lit_ready_after_rst", i_ready, 1'b1);
    step();

    // store then load of the same word on the next cycle
    o_cdb_ready = 1'b1;
    issue(I_STORE, 4'd0, 32'h10, 32'hDEADBEEF);
    issue(I_LOAD, 4'd5, 32'h10, 32'h0);
    @(negedge clk);
    chk1("lit_load_not_yet", o_cdb_valid, 1'b0);
    @(negedge clk);
    chk1("lit_load_valid", o_cdb_valid, 1'b1);
    chkv("lit_load_data", o_cdb, {4'd5, 32'hDEADBEEF});
    step();

    // aliasing through ignored upper address bits
    issue(I_STOREB, 4'd0, 32'h1010, 32'h1234);
    issue(I_LOADR, 4'd1, 32'h0010, 32'h0);
    wait_cdb(v);
    chkv("lit_alias", v, {4'd1, 32'h1234});
    step();

    // CDB backpressure for 7 cycles
    o_cdb_ready = 1'b0;
    issue(I_LOAD, 4'd7, 32'h10, 32'h0);
    @(negedge clk);
    repeat (7) begin
      @(negedge clk);
      chk1("lit_bp_valid", o_cdb_valid, 1'b1);
      chkv("lit_bp_data", o_cdb, {4'd7, 32'h1234});
      chk1("lit_bp_iready", i_ready, 1'b0);
    end
    step();
    o_cdb_ready = 1'b1;
    step();
    o_cdb_ready = 1'b0;
    @(negedge clk);
    chk1("lit_bp_release", i_ready, 1'b1);
    step();

    // input with an empty FIFO, byte arrives later
    o_cdb_ready = 1'b1;
    issue(I_INPUT, 4'd3, 32'h0, 32'h0);
    repeat (10) step();
    send_byte(8'h41);
    wait_cdb(v);
    chkv("lit_input", v, {4'd3, 32'h41});
    step();

    // RX overflow: 16 queued, 17th held until an input pops
    for (int i = 0; i < 16; i++) send_byte(8'h60 + 8'(i));
    @(negedge clk);
    chk1("lit_rx_full", rx_ready, 1'b0);
    step();
    rx_valid = 1'b1;
    rx_data = 8'hEE;
    repeat (3) begin
      @(negedge clk);
      chk1("lit_rx_held", rx_ready, 1'b0);
    end
    step();
    fork
      send_byte(8'hEE);
      begin
        issue(I_INPUT, 4'd2, 32'h0, 32'h0);
        wait_cdb(v);
        chkv("lit_ovf_first", v, {4'd2, 32'h60});
      end
    join
    step();
    for (int i = 0; i < 16; i++) begin
      issue(I_INPUT, 4'(i), 32'h0, 32'h0);
      wait_cdb(v);
      if (i == 15) chkv("lit_ovf_last", v, {4'd15, 32'hEE});
      step();
    end

    // output with TX backpressure
    tx_ready = 1'b0;
    issue(I_OUTPUT, 4'd0, 32'h0, 32'hABCD1255);
    hs0 = tx_hs;
    repeat (4) begin
      @(negedge clk);
      chk1("lit_tx_valid", tx_valid, 1'b1);
      chkv("lit_tx_data", CDB_W'(tx_data), CDB_W'(8'h55));
    end
    step();
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    @(negedge clk);
    chk1("lit_tx_done", tx_valid, 1'b0);
    chk1("lit_tx_no_cdb", o_cdb_valid, 1'b0);
    step();
    total++;
    if (tx_hs - hs0 != 1) begin
      bad++;
      $display("FAIL lit_tx_once: got %0d handshakes expected 1", tx_hs - hs0);
    end

    // reset while a result is pending
    send_byte(8'h99);
    o_cdb_ready = 1'b0;
    issue(I_LOAD, 4'd4, 32'h10, 32'h0);
    wait_cdb(v);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk1("lit_rst_cdb_valid", o_cdb_valid, 1'b0);
    chk1("lit_rst_idle", state_dbg == IDLE, 1'b1);
    chk1("lit_rst_iready", i_ready, 1'b1);
    step();
    o_cdb_ready = 1'b1;
    issue(I_INPUT, 4'd6, 32'h0, 32'h0);
    repeat (3) step();
    send_byte(8'h77);
    wait_cdb(v);
    chkv("lit_rst_fifo_empty", v, {4'd6, 32'h77});
    step();
    issue(I_LOAD, 4'd9, 32'h10, 32'h0);
    wait_cdb(v);
    chkv("lit_rst_ram_kept", v, {4'd9, 32'h1234});
    step();

    // randomized phase
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      a[11:0] = idx_tab[i];
      issue(I_STORE, 4'd0, a, $urandom);
    end
    rand_ready = 1;
    rand_rx = 1;
    fork
      while (rand_rx) begin
        if ($urandom_range(0, 2) == 0) send_byte(8'($urandom));
        else step();
      end
      begin
        for (int i = 0; i < 400; i++) begin
          a = $urandom;
          a[11:0] = idx_tab[$urandom_range(0, 7)];
          issue(op_tab[$urandom_range(0, 11)], 4'($urandom), a, $urandom);
          if ($urandom_range(0, 3) == 0) step();
        end
        rand_rx = 0;
      end
    join
    send_byte(8'h5A);
    n = 0;
    forever begin
      @(negedge clk);
      if (i_ready) break;
      n++;
      if (n > 500) begin
        timeout("final_drain");
        break;
      end
    end
    step();
    rand_ready = 0;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Target side of the memory functional unit request port (valid/opcode/rsv_id/address/data/ready).
- Executes stores into an internal synchronous data RAM and loads out of it, and returns load results on a CDB output as {rsv_id, data}.
- I_INPUT and I_OUTPUT map to byte streams: an RX stream buffered in a FIFO, and a TX stream.
- Sits between the memory functional unit and the CDB arbiter, next to the UART.

Parameters:
- RAM_ADDR_W, 12, word-address width of data RAM (2**RAM_ADDR_W words of DATA_W).
- RX_FIFO_DEPTH_W, 4, depth exponent of RX byte FIFO.

Ports:
- clk  in  1  clock
- i_valid  in  1  request valid
- i_opcode  in  INSTR_W  request opcode
- i_rsv_id  in  RSV_ID_W  ROB id of request
- i_address  in  DATA_W  computed word address
- i_data  in  DATA_W  store data
- i_ready  out  1  request accepted when i_valid & i_ready
- o_cdb  out  CDB_W  {rsv_id, load data}
- o_cdb_valid  out  1  result valid
- o_cdb_ready  in  1  CDB arbiter accepts
- rx_valid  in  1  incoming byte valid
- rx_data  in  8  incoming byte
- rx_ready  out  1  RX FIFO not full
- tx_valid  out  1  outgoing byte valid
- tx_data  out  8  outgoing byte
- tx_ready  in  1  sink accepts
- rst  in  1  synchronous active-high reset (single clock domain clk)

Behaviour:
- Opcode classes:
  - Load = I_LOAD, I_LOADB, I_LOADR; all three behave identically here.
  - Store = I_STORE, I_STOREB, I_STORER; all three behave identically here.
  - Input = I_INPUT. Output = I_OUTPUT.
  - Any other opcode is accepted and dropped: no RAM write, no response.
- RAM index = i_address[RAM_ADDR_W-1:0]. Upper bits are ignored (aliasing). Write-first is not required.
- FSM states: IDLE, LOAD_RD, RESP, IN_WAIT, OUT_WAIT.
- i_ready = 1 only in IDLE and not in reset.
- IDLE transitions:
  - Store accepted: RAM written at this edge; stay IDLE. Zero-cycle occupancy, so back-to-back stores run at 1 per cycle.
  - Load accepted: latch rsv_id, issue RAM read; go LOAD_RD.
  - Input accepted: latch rsv_id; go IN_WAIT.
  - Output accepted: latch i_data[7:0]; go OUT_WAIT.
- LOAD_RD: RAM data registered into the result; go RESP. Result is visible on o_cdb 2 cycles after accept.
- IN_WAIT:
  - When the RX FIFO is non-empty, pop one byte; result data = zero-extended byte; go RESP.
  - If a byte is already queued, RESP is reached the next cycle.
- RESP: o_cdb_valid = 1, o_cdb = {latched rsv_id, result}.
  - Hold o_cdb stable until o_cdb_ready; on the handshake go IDLE.
  - o_cdb_ready low indefinitely stalls the block; i_ready stays 0.
- OUT_WAIT: tx_valid = 1, tx_data = latched byte, held stable; on tx_ready go IDLE.
- Ordering: strictly in order. A store followed by a load to the same address on the next cycle returns the new data.
- RX FIFO:
  - rx_ready = !full; a byte arriving while full is not accepted (sender holds it).
  - Push and pop in the same cycle are allowed at any occupancy, including full.
  - Bytes may arrive in any state.
- Reset (rst high at a clock edge):
  - FSM -> IDLE; RX FIFO emptied; any pending response or TX byte discarded.
  - i_ready = 0 during reset, 1 the first cycle after.
  - o_cdb_valid = 0, o_cdb = 0, tx_valid = 0, tx_data = 0, rx_ready = 0 during reset.
  - RAM contents are not cleared.
  - Reset mid-RESP drops the result without a handshake.
- No combinational path from o_cdb_ready or tx_ready to i_ready. All outputs are registered or decoded from the state register.

Decomposition:
- fcpu_pkg already supplies INSTR_W, RSV_ID_W, DATA_W, CDB_W and the opcodes.
- Add to fcpu_pkg:
  - mem_resp_state_t enum (IDLE, LOAD_RD, RESP, IN_WAIT, OUT_WAIT).
  - Helper functions is_load_op(opcode) and is_store_op(opcode). These are reusable by the memory functional unit in place of its open-coded compares.
- Sub-modules:
  - RX buffer: instantiate the existing fifo with FIFO_DEPTH_W = RX_FIFO_DEPTH_W, DATA_W = 8.
  - RAM: an inferred array inside the block. No separate module.

Test Plan:
- Store, then load, same address: store addr 0x10 data 0xDEADBEEF, then load rsv_id 5 addr 0x10 on the next cycle -> o_cdb = {5, 0xDEADBEEF} exactly 2 cycles after load accept.
- Aliasing: store addr 0x1010 data 0x1234 (RAM_ADDR_W = 12), load addr 0x0010 -> returns 0x1234.
- CDB backpressure: load with o_cdb_ready held 0 for 7 cycles -> o_cdb_valid and o_cdb stable, i_ready = 0 throughout; one handshake, then i_ready = 1 the next cycle.
- Input:
  - Input issued with the FIFO empty: rsv_id 3, rx byte 0x41 sent 10 cycles later -> o_cdb = {3, 0x00000041}.
  - RX overflow: 16 bytes pushed with no input ops -> rx_ready = 0; 17th byte held until an input op pops one.
- Output: output with data 0xABCD1255, tx_ready low 4 cycles -> tx_data = 0x55 held; exactly one TX handshake; no CDB result.
- Reset: rst asserted while in RESP -> o_cdb_valid = 0 the next cycle, FSM IDLE, FIFO empty; a load issued after reset of a pre-reset stored address returns the old data.
